// File: rtl/ram_wishbone_pkg.sv
// ram_wishbone_pkg: bus-slave FSM states and lane-count helper shared by the Wishbone slaves.
package ram_wishbone_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} wb_state_e;
   function automatic int wb_sel_w(input int dw);
      return dw / 8;
   endfunction
endpackage

// File: rtl/ram_bytelane.sv
// ram_bytelane: single-port RAM with per-byte write enables and registered read.
module ram_bytelane #(
  parameter int    DW      = 32,
  parameter int    DEPTH   = 1024,
  parameter int    IW      = 10,
  parameter string MEMFILE = ""
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [IW-1:0]   idx_i,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DW / 8; b++)
      if (en_i && we_i && sel_i[b]) mem_q[idx_i][b*8 +: 8] <= dat_i[b*8 +: 8];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dat_o <= '0;
    else if (en_i && !we_i) dat_o <= mem_q[idx_i];
  end
endmodule

// File: rtl/ram_wishbone.sv
// ram_wishbone: Wishbone B4 classic slave RAM/ROM with byte lanes, wait states, ERR decode and abort.
module ram_wishbone
   import ram_wishbone_pkg::*;
#(
   parameter int    ADDRESS_WIDTH = 32,
   parameter int    DATA_WIDTH    = 32,
   parameter int    DEPTH         = 1024,
   parameter int    WAIT_STATES   = 0,
   parameter bit    READ_ONLY     = 1'b0,
   parameter string MEMFILE       = ""
) (
   input  logic                               CLK_I,
   input  logic                               RST_NI,
   input  logic                               CYC_I,
   input  logic                               STB_I,
   input  logic                               WE_I,
   input  logic [wb_sel_w(DATA_WIDTH)-1:0]    SEL_I,
   input  logic [ADDRESS_WIDTH-1:0]           ADR_I,
   input  logic [DATA_WIDTH-1:0]              DAT_I,
   output logic [DATA_WIDTH-1:0]              DAT_O,
   output logic                               ACK_O,
   output logic                               ERR_O
);
   localparam int SW = wb_sel_w(DATA_WIDTH);
   localparam int SH = $clog2(SW);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   wb_state_e st_q, st_d;
   logic [3:0] cnt_q, cnt_d;
   logic we_q, bad_q, ack_q, err_q;
   logic [SW-1:0] sel_q, cur_sel;
   logic [IW-1:0] idx_q, cur_idx;
   logic [DATA_WIDTH-1:0] dat_q, cur_dat;
   logic [ADDRESS_WIDTH-1:0] word;
   logic idle, req, new_bad, cur_we, cur_bad, go_resp, ram_en;
   assign word    = ADR_I >> SH;
   assign new_bad = (word >= ADDRESS_WIDTH'(DEPTH)) || (READ_ONLY && WE_I);
   assign idle    = st_q == S_IDLE;
   assign req     = idle && CYC_I && STB_I;
   // with zero wait states the access happens on the sampling edge, so use the live bus values
   assign cur_we  = idle ? WE_I : we_q;
   assign cur_bad = idle ? new_bad : bad_q;
   assign cur_sel = idle ? SEL_I : sel_q;
   assign cur_idx = idle ? IW'(word) : idx_q;
   assign cur_dat = idle ? DAT_I : dat_q;
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (req) begin
         cnt_d = 4'(WAIT_STATES);
         st_d  = WAIT_STATES > 0 ? S_WAIT : S_RESP;
      end else if (st_q == S_WAIT) begin
         cnt_d = CYC_I ? cnt_q - 4'd1 : 4'd0;
         st_d  = !CYC_I ? S_IDLE : cnt_q == 4'd1 ? S_RESP : S_WAIT;
      end else if (st_q == S_RESP) begin
         st_d = S_IDLE;
      end
   end
   assign go_resp = st_d == S_RESP;
   assign ram_en  = go_resp && !cur_bad && RST_NI;
   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         st_q  <= S_IDLE;
         cnt_q <= '0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
         we_q  <= 1'b0;
         bad_q <= 1'b0;
         sel_q <= '0;
         idx_q <= '0;
         dat_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         ack_q <= go_resp && !cur_bad;
         err_q <= go_resp && cur_bad;
         if (req) begin
            we_q  <= WE_I;
            bad_q <= new_bad;
            sel_q <= SEL_I;
            idx_q <= IW'(word);
            dat_q <= DAT_I;
         end
      end
   end
   ram_bytelane #(.DW(DATA_WIDTH), .DEPTH(DEPTH), .IW(IW), .MEMFILE(MEMFILE)) u_ram (
      .clk_i (CLK_I),
      .rst_ni(RST_NI),
      .en_i  (ram_en),
      .we_i  (cur_we),
      .sel_i (cur_sel),
      .idx_i (cur_idx),
      .dat_i (cur_dat),
      .dat_o (DAT_O)
   );
   assign ACK_O = ack_q;
   assign ERR_O = err_q;
endmodule

// File: tb/tb_ram_wishbone.sv
// tb_ram_wishbone: random and directed Wishbone transfers on three slave configurations vs an array model.
module tb_ram_wishbone;
   localparam int DEP = 64;
   logic clk = 1'b0, rst_n = 1'b0, stb = 1'b0, we = 1'b0;
   logic cyc [3];
   logic ack [3];
   logic err [3];
   logic [31:0] rdat [3];
   logic [3:0] sel = '0;
   logic [31:0] adr = '0, wdat = '0, q;
   int ws [3] = '{0, 3, 0};
   bit ro [3] = '{0, 0, 1};
   logic [31:0] mdl [3][DEP];
   bit known [3][DEP];
   logic [31:0] last [3];
   bit last_ok [3];
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   ram_wishbone #(.DEPTH(DEP), .WAIT_STATES(0)) u0 (
      .CLK_I(clk), .RST_NI(rst_n), .CYC_I(cyc[0]), .STB_I(stb), .WE_I(we), .SEL_I(sel),
      .ADR_I(adr), .DAT_I(wdat), .DAT_O(rdat[0]), .ACK_O(ack[0]), .ERR_O(err[0]));
   ram_wishbone #(.DEPTH(DEP), .WAIT_STATES(3)) u1 (
      .CLK_I(clk), .RST_NI(rst_n), .CYC_I(cyc[1]), .STB_I(stb), .WE_I(we), .SEL_I(sel),
      .ADR_I(adr), .DAT_I(wdat), .DAT_O(rdat[1]), .ACK_O(ack[1]), .ERR_O(err[1]));
   ram_wishbone #(.DEPTH(DEP), .WAIT_STATES(0), .READ_ONLY(1'b1)) u2 (
      .CLK_I(clk), .RST_NI(rst_n), .CYC_I(cyc[2]), .STB_I(stb), .WE_I(we), .SEL_I(sel),
      .ADR_I(adr), .DAT_I(wdat), .DAT_O(rdat[2]), .ACK_O(ack[2]), .ERR_O(err[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd);
      int n, idx;
      bit bad;
      n   = 0;
      idx = int'(a >> 2);
      bad = (a >> 2) >= 32'(DEP) || (ro[k] && w);
      @(negedge clk);
      cyc[k] = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
      do begin
         @(posedge clk); #1; n++;
      end while (!(ack[k] || err[k]) && n < 40);
      rd = rdat[k];
      chk($sformatf("latency k%0d a%h", k, a), n, 1 + ws[k]);
      chk($sformatf("ack k%0d a%h", k, a), 32'(ack[k]), 32'(!bad));
      chk($sformatf("err k%0d a%h", k, a), 32'(err[k]), 32'(bad));
      if (!bad && !w) begin
         if (known[k][idx]) chk($sformatf("rdata k%0d a%h", k, a), rd, mdl[k][idx]);
         last[k] = rd; last_ok[k] = known[k][idx];
      end else if (bad && last_ok[k]) chk($sformatf("hold k%0d a%h", k, a), rd, last[k]);
      if (!bad && w) begin
         for (int b = 0; b < 4; b++) if (s[b]) mdl[k][idx][b*8 +: 8] = d[b*8 +: 8];
         if (s == 4'hF) known[k][idx] = 1'b1;
      end
      cyc[k] = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("pulse k%0d", k), {30'd0, ack[k], err[k]}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t, prev, n;
      logic seen;
      for (int k = 0; k < 3; k++) begin cyc[k] = 1'b0; last[k] = '0; last_ok[k] = 1'b1; end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_ack%0d", k), 32'(ack[k]), 0);
         chk($sformatf("rst_err%0d", k), 32'(err[k]), 0);
         chk($sformatf("rst_dat%0d", k), rdat[k], 0);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < DEP; i++) xfer(k, 1'b1, 32'(i * 4), 4'hF, $urandom, q);
      // basic write/read
      xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, q);
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, q);
      chk("t1_data", q, 32'hDEADBEEF);
      // byte lanes, SEL does not mask reads
      xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, q);
      xfer(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, q);
      xfer(0, 1'b0, 32'h20, 4'b0001, 32'h0, q);
      chk("t2_data", q, 32'h11BB33DD);
      xfer(0, 1'b1, 32'h20, 4'h0, 32'h55667788, q);
      xfer(0, 1'b0, 32'h23, 4'hF, 32'h0, q);
      chk("sel0_misaligned", q, 32'h11BB33DD);
      // wait states and abort
      xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, q);
      @(negedge clk);
      cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; sel = 4'hF; wdat = ~mdl[1][12];
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc[1] = 1'b0; stb = 1'b0;
      seen = 1'b0;
      repeat (8) begin @(posedge clk); #1; seen |= ack[1] | err[1]; end
      chk("abort_term", 32'(seen), 0);
      xfer(1, 1'b0, 32'h30, 4'hF, 32'h0, q);
      chk("abort_data", q, mdl[1][12]);
      // decode errors and ROM writes
      xfer(0, 1'b0, 32'(DEP * 4), 4'hF, 32'h0, q);
      xfer(0, 1'b1, 32'(DEP * 4 + 8), 4'hF, 32'h12345678, q);
      xfer(1, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, q);
      xfer(2, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, q);
      xfer(2, 1'b0, 32'h0, 4'hF, 32'h0, q);
      // back-to-back reads with STB held
      @(negedge clk);
      cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
      t = 0; prev = 0;
      for (int j = 0; j < 3; j++) begin
         n = 0;
         do begin @(posedge clk); #1; t++; n++; end while (!ack[0] && n < 10);
         chk($sformatf("b2b_data%0d", j), rdat[0], mdl[0][j]);
         chk($sformatf("b2b_gap%0d", j), 32'(t - prev), j == 0 ? 32'd1 : 32'd2);
         prev = t;
         adr = 32'((j + 1) * 4);
      end
      cyc[0] = 1'b0; stb = 1'b0;
      last[0] = mdl[0][2];
      @(posedge clk); #1;
      // reset while a write is waiting
      @(negedge clk);
      cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h34; sel = 4'hF; wdat = ~mdl[1][13];
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      chk("rst_mid_ack", 32'(ack[1]), 0);
      chk("rst_mid_err", 32'(err[1]), 0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_mid_dat%0d", k), rdat[k], 0);
         last[k] = '0; last_ok[k] = 1'b1;
      end
      cyc[1] = 1'b0; stb = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      xfer(1, 1'b0, 32'h34, 4'hF, 32'h0, q);
      chk("rst_mid_data", q, mdl[1][13]);
      // random traffic, including misaligned and out-of-range addresses
      repeat (300) begin
         xfer($urandom_range(0, 2), 1'($urandom), 32'($urandom_range(0, DEP + 3) * 4 + $urandom_range(0, 3)),
              4'($urandom), $urandom, q);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
